// File: rtl/pmu_acs64_pkg.sv
// pmu_acs64_pkg: trellis parameters and branch-label helpers for the K=7 rate-1/2 path-metric unit
package pmu_acs64_pkg;
    localparam int K = 7;
    localparam int NS = 1 << (K - 1);
    localparam int PM_W = 8;
    localparam int INIT_PM = 64;
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;
    typedef logic [PM_W-1:0] pm_t;
    typedef logic [K-2:0] st_t;
    typedef logic [3:0][1:0] bm_t;
    function automatic logic [1:0] exp_pair(input logic u, input st_t p);
        return {^({u, p} & G1), ^({u, p} & G0)};
    endfunction
    function automatic pm_t init_pm(input int s);
        return s == 0 ? '0 : pm_t'(INIT_PM);
    endfunction
endpackage

// File: rtl/pmu_acs64_acs_node.sv
// pmu_acs64_acs_node: add-compare-select for one trellis state; ties keep the even predecessor
module pmu_acs64_acs_node
    import pmu_acs64_pkg::*;
(
    input  logic [PM_W-1:0] pm0_i,
    input  logic [1:0]      bm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);
    logic [PM_W:0] a;
    logic [PM_W:0] b;
    assign a = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
    assign b = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
    assign dec_o = b < a;
    assign pm_o = dec_o ? b[PM_W-1:0] : a[PM_W-1:0];
endmodule

// File: rtl/pmu_acs64.sv
// pmu_acs64: 64-state Viterbi path-metric unit with normalisation, argmin and a
// valid/ready decision output register
module pmu_acs64
    import pmu_acs64_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            bm_valid_i,
    output logic            bm_ready_o,
    input  logic [1:0]      bm_00_i,
    input  logic [1:0]      bm_01_i,
    input  logic [1:0]      bm_10_i,
    input  logic [1:0]      bm_11_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [NS-1:0]   dec_o,
    output logic [K-2:0]    best_state_o,
    output logic [PM_W-1:0] best_pm_o
);
    pm_t [NS-1:0] pm_q, pm_d, base, acs, norm;
    logic [NS-1:0] dec_d, dec_q;
    bm_t bm;
    logic fire, all_msb, dec_valid_d, dec_valid_q;
    st_t best_state_d, best_state_q;
    pm_t best_pm_d, best_pm_q;

    assign bm = {bm_11_i, bm_10_i, bm_01_i, bm_00_i};
    assign bm_ready_o = !dec_valid_q | dec_ready_i;
    assign fire = bm_valid_i & bm_ready_o;
    assign dec_valid_d = fire | (dec_valid_q & !dec_ready_i);

    // A start in the same cycle as a step makes that symbol the first of the new frame.
    always_comb begin
        for (int i = 0; i < NS; i++) base[i] = start_i ? init_pm(i) : pm_q[i];
    end

    genvar j;
    generate
        for (j = 0; j < NS; j++) begin : g_node
            localparam st_t JS = st_t'(j);
            localparam st_t P0 = {JS[K-3:0], 1'b0};
            localparam st_t P1 = {JS[K-3:0], 1'b1};
            pmu_acs64_acs_node u_acs (
                .pm0_i(base[P0]),
                .bm0_i(bm[exp_pair(JS[K-2], P0)]),
                .pm1_i(base[P1]),
                .bm1_i(bm[exp_pair(JS[K-2], P1)]),
                .pm_o (acs[j]),
                .dec_o(dec_d[j])
            );
        end
    endgenerate

    always_comb begin
        all_msb = 1'b1;
        best_state_d = '0;
        best_pm_d = '1;
        for (int i = 0; i < NS; i++) all_msb = all_msb & acs[i][PM_W-1];
        for (int i = 0; i < NS; i++) begin
            norm[i] = {acs[i][PM_W-1] & !all_msb, acs[i][PM_W-2:0]};
            pm_d[i] = fire ? norm[i] : base[i];
            if (norm[i] < best_pm_d) begin
                best_pm_d = norm[i];
                best_state_d = st_t'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NS; i++) pm_q[i] <= init_pm(i);
            dec_valid_q <= 1'b0;
            dec_q <= '0;
            best_state_q <= '0;
            best_pm_q <= '0;
        end else begin
            pm_q <= pm_d;
            dec_valid_q <= dec_valid_d;
            if (fire) begin
                dec_q <= dec_d;
                best_state_q <= best_state_d;
                best_pm_q <= best_pm_d;
            end
        end
    end

    assign dec_valid_o = dec_valid_q;
    assign dec_o = dec_q;
    assign best_state_o = best_state_q;
    assign best_pm_o = best_pm_q;
endmodule

// File: tb/tb_pmu_acs64.sv
// tb_pmu_acs64: randomized and directed checks of pmu_acs64 against an
// integer trellis model with a normalised and an unbounded metric copy
module tb_pmu_acs64;
    logic clk = 1'b0;
    logic rst_n, start, bm_valid, bm_ready, dec_valid, dec_ready;
    logic [1:0] bm00, bm01, bm10, bm11;
    logic [63:0] dec;
    logic [5:0] best_state;
    logic [7:0] best_pm;
    int n_tests = 0;
    int n_fail = 0;
    int mpm[64];
    int rpm[64];
    logic [63:0] mdec, rdec;
    int mbs, mbp;
    bit mvalid;
    int b[4];

    always #5 clk = ~clk;

    pmu_acs64 dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .bm_valid_i(bm_valid),
        .bm_ready_o(bm_ready), .bm_00_i(bm00), .bm_01_i(bm01), .bm_10_i(bm10),
        .bm_11_i(bm11), .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .dec_o(dec), .best_state_o(best_state), .best_pm_o(best_pm)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // code bits of the branch leaving state p on input u, as index {c1,c0}
    function automatic int code(input int u, input int p);
        int v;
        v = u * 64 + p;
        return ($countones(v & 'o133) & 1) * 2 + ($countones(v & 'o171) & 1);
    endfunction

    task automatic mreset_pm();
        for (int j = 0; j < 64; j++) begin
            mpm[j] = (j == 0) ? 0 : 64;
            rpm[j] = mpm[j];
        end
    endtask

    task automatic mstep(input int bv[4]);
        int n[64];
        int r[64];
        int p, a, c;
        bit all;
        all = 1;
        for (int j = 0; j < 64; j++) begin
            p = (2 * j) % 64;
            a = mpm[p] + bv[code(j / 32, p)];
            c = mpm[p + 1] + bv[code(j / 32, p + 1)];
            n[j] = (c < a) ? c : a;
            mdec[j] = c < a;
            a = rpm[p] + bv[code(j / 32, p)];
            c = rpm[p + 1] + bv[code(j / 32, p + 1)];
            r[j] = (c < a) ? c : a;
            rdec[j] = c < a;
            if (n[j] < 128) all = 0;
        end
        for (int j = 0; j < 64; j++) begin
            mpm[j] = all ? n[j] - 128 : n[j];
            rpm[j] = r[j];
        end
        mbs = 0;
        mbp = mpm[0];
        for (int j = 1; j < 64; j++) if (mpm[j] < mbp) begin
            mbp = mpm[j];
            mbs = j;
        end
        mvalid = 1;
    endtask

    task automatic do_reset();
        bm_valid = 0;
        start = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        mreset_pm();
        mvalid = 0;
        mdec = '0;
        mbs = 0;
        mbp = 0;
        check("rst_dec_valid", dec_valid, 0);
        check("rst_bm_ready", bm_ready, 1);
        check("rst_dec", dec, 0);
        check("rst_best_pm", best_pm, 0);
        rst_n = 1;
    endtask

    task automatic cyc(input bit v, input bit r, input bit st, input int bv[4]);
        bit fire;
        bm_valid = v;
        dec_ready = r;
        start = st;
        bm00 = 2'(bv[0]);
        bm01 = 2'(bv[1]);
        bm10 = 2'(bv[2]);
        bm11 = 2'(bv[3]);
        #1;
        check("bm_ready", bm_ready, !mvalid | r);
        @(posedge clk);
        fire = v & (!mvalid | r);
        if (st) mreset_pm();
        if (fire) mstep(bv);
        else if (r) mvalid = 0;
        #1;
        bm_valid = 0;
        start = 0;
        check("dec_valid", dec_valid, mvalid);
        check("dec", dec, mdec);
        check("best_state", best_state, mbs);
        check("best_pm", best_pm, mbp);
    endtask

    task automatic rnd_b();
        int c;
        c = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) b[k] = $countones(k ^ c);
    endtask

    initial begin
        int s, u;
        int us[7];
        logic [63:0] sd;
        logic [7:0] sp;
        logic [5:0] ss;
        dec_ready = 1;
        bm00 = 0; bm01 = 0; bm10 = 0; bm11 = 0;
        do_reset();

        b = '{0, 0, 0, 0};
        cyc(1, 1, 0, b);
        check("t1_best_pm", best_pm, 0);
        check("t1_best_state", best_state, 0);

        b = '{0, 1, 1, 2};
        repeat (20) begin
            cyc(1, 1, 0, b);
            check("t2_valid", dec_valid, 1);
            check("t2_state", best_state, 0);
            check("t2_pm", best_pm, 0);
            check("t2_dec0", dec[0], 0);
        end

        us = '{1, 0, 1, 1, 0, 0, 1};
        s = 0;
        for (int i = 0; i < 7; i++) begin
            u = us[i];
            for (int k = 0; k < 4; k++) b[k] = $countones(k ^ code(u, s));
            s = u * 32 + s / 2;
            cyc(1, 1, i == 0, b);
            check("t3_enc_state", best_state, s);
            check("t3_pm", best_pm, 0);
        end

        sd = dec; sp = best_pm; ss = best_state;
        rnd_b();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, b);
            check("t4_stall_ready", bm_ready, 0);
            check("t4_dec_hold", dec, sd);
            check("t4_pm_hold", best_pm, sp);
            check("t4_state_hold", best_state, ss);
        end
        cyc(1, 1, 0, b);
        cyc(0, 1, 0, b);
        check("t4_drain", dec_valid, 0);

        b = '{2, 2, 2, 2};
        for (int i = 0; i < 200; i++) begin
            cyc(1, 1, 0, b);
            check("t5_raw_dec", dec, rdec);
        end

        rnd_b();
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, b);
        rnd_b();
        cyc(1, 1, 1, b);
        b = '{1, 1, 1, 1};
        cyc(1, 1, 1, b);
        check("t6_tie_dec", dec, 0);
        sd = dec;
        cyc(0, 0, 1, b);
        check("t6_start_alone", dec, sd);
        rnd_b();
        cyc(1, 1, 0, b);

        cyc(1, 0, 0, b);
        do_reset();
        dec_ready = 1;

        for (int i = 0; i < 400; i++) begin
            rnd_b();
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
